// File: rtl/sram_b_rd_pkg.sv
// Shared FSM encoding and output-buffer depth for the sram_b burst reader.
// Optional feature macro used by the reader: SRAM_B_RD_STRIDE_EN.
package sram_b_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/sram_b_stream_reader_if.sv
// Command, output stream and SRAM read-port bundle for sram_b_stream_reader.
// cmd_stride exists only when SRAM_B_RD_STRIDE_EN is defined.
interface sram_b_stream_reader_if #(
    parameter int ABITS = 14,
    parameter int DBITS = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [ABITS-1:0] cmd_addr;
    logic [ABITS:0]   cmd_len;
`ifdef SRAM_B_RD_STRIDE_EN
    logic [ABITS-1:0] cmd_stride;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [DBITS-1:0] out_data;
    logic             out_last;
    logic             busy;
    logic             CE1;
    logic [ABITS-1:0] A1;
    logic [DBITS-1:0] Q1;

    // Reader side: accepts commands, drives the stream and the SRAM read port.
    modport slave (
        input  cmd_valid, cmd_addr, cmd_len,
`ifdef SRAM_B_RD_STRIDE_EN
        input  cmd_stride,
`endif
        output cmd_ready,
        output out_valid, out_data, out_last,
        input  out_ready,
        output busy, CE1, A1,
        input  Q1
    );

    // Requester / consumer / SRAM side.
    modport master (
        output cmd_valid, cmd_addr, cmd_len,
`ifdef SRAM_B_RD_STRIDE_EN
        output cmd_stride,
`endif
        input  cmd_ready,
        input  out_valid, out_data, out_last,
        output out_ready,
        input  busy, CE1, A1,
        output Q1
    );
endinterface

// File: rtl/sram_b_rd_fifo2.sv
// Two-entry {last,data} FIFO; push and pop may coincide, the head is combinational.
// Caller guarantees no push when full without a same-cycle pop; sync active-high reset.
module sram_b_rd_fifo2 #(
    parameter int DBITS = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_push,
    input  logic [DBITS-1:0] i_push_data,
    input  logic             i_push_last,
    input  logic             i_pop,
    output logic [1:0]       o_count,
    output logic [DBITS-1:0] o_head_data,
    output logic             o_head_last
);
    logic [DBITS-1:0] r_data [2];
    logic             r_last [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 2; i++) begin
                r_data[i] <= '0;
                r_last[i] <= 1'b0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_data[r_wr_ptr] <= i_push_data;
                r_last[r_wr_ptr] <= i_push_last;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_count     = r_count;
    assign o_head_data = r_data[r_rd_ptr];
    assign o_head_last = r_last[r_rd_ptr];
endmodule

// File: rtl/sram_b_stream_reader.sv
// Burst reader for the sram_b 1r port: issues CE1/A1 and streams Q1 out as valid/ready.
// Optional SRAM_B_RD_STRIDE_EN adds a per-command address stride (default increment 1).
module sram_b_stream_reader
    import sram_b_rd_pkg::*;
#(
    parameter int ABITS = 14,
    parameter int DBITS = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    sram_b_stream_reader_if.slave  bus
);
    rd_state_t        r_state;
    logic [ABITS-1:0] r_addr;
    logic [ABITS:0]   r_rem;
    logic             r_inflight;
    logic             r_inflight_last;
    logic [ABITS-1:0] w_inc;

    logic [1:0]       w_cnt;
    logic [DBITS-1:0] w_head_data;
    logic             w_head_last;
    logic             w_out_vld;
    logic             w_pop;
    logic [2:0]       w_occ;
    logic             w_credit;
    logic             w_rem_one;
    logic             w_issue;
    logic             w_last_pop;
    logic             w_drained;

`ifdef SRAM_B_RD_STRIDE_EN
    logic [ABITS-1:0] r_stride;
    assign w_inc = r_stride;
`else
    assign w_inc = ABITS'(1);
`endif

    assign w_out_vld  = (w_cnt != 2'd0);
    assign w_pop      = w_out_vld & bus.out_ready;
    // Occupancy counts the word still inside the SRAM output register.
    assign w_occ      = {1'b0, w_cnt} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign w_credit   = (w_occ < 3'(FIFO_DEPTH));
    assign w_rem_one  = (r_rem == (ABITS+1)'(1));
    assign w_issue    = !RST && (r_state == ST_RUN) && (r_rem != '0) && w_credit;
    assign w_last_pop = w_pop & w_head_last;
    assign w_drained  = (w_cnt == 2'd0) && !r_inflight;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state         <= ST_IDLE;
            r_addr          <= '0;
            r_rem           <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
`ifdef SRAM_B_RD_STRIDE_EN
            r_stride        <= '0;
`endif
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue & w_rem_one;
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_addr  <= bus.cmd_addr;
                        r_rem   <= bus.cmd_len;
`ifdef SRAM_B_RD_STRIDE_EN
                        r_stride <= bus.cmd_stride;
`endif
                        r_state <= (bus.cmd_len == '0) ? ST_DRAIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_issue) begin
                        r_addr <= r_addr + w_inc;
                        r_rem  <= r_rem - (ABITS+1)'(1);
                        if (w_rem_one) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // The drained term releases zero-length bursts, which never tag a last.
                    if (w_last_pop || w_drained) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    sram_b_rd_fifo2 #(.DBITS(DBITS)) u_fifo (
        .CLK         (CLK),
        .RST         (RST),
        .i_push      (r_inflight),
        .i_push_data (bus.Q1),
        .i_push_last (r_inflight_last),
        .i_pop       (w_pop),
        .o_count     (w_cnt),
        .o_head_data (w_head_data),
        .o_head_last (w_head_last)
    );

    assign bus.cmd_ready = (r_state == ST_IDLE);
    assign bus.busy      = (r_state != ST_IDLE) && !w_last_pop;
    assign bus.CE1       = w_issue;
    assign bus.A1        = r_addr;
    assign bus.out_valid = w_out_vld;
    assign bus.out_data  = w_out_vld ? w_head_data : '0;
    assign bus.out_last  = w_out_vld & w_head_last;
endmodule

// File: tb/tb_sram_b_stream_reader.sv
// Bench for sram_b_stream_reader with a behavioural 1-cycle SRAM preloaded mem[i]=i[7:0].
module tb_sram_b_stream_reader;
    localparam int ABITS = 14;
    localparam int DBITS = 8;
    localparam int BOUND = 2000;

    typedef struct {
        logic [7:0] d;
        logic       last;
    } beat_t;

    logic CLK;
    logic RST;
    int   checks   = 0;
    int   failures = 0;
    int   rdy_mode = 0;

    sram_b_stream_reader_if #(.ABITS(ABITS), .DBITS(DBITS)) bus ();

    sram_b_stream_reader #(.ABITS(ABITS), .DBITS(DBITS)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [7:0] mem [1<<ABITS];
    initial for (int i = 0; i < (1<<ABITS); i++) mem[i] = i[7:0];
    always @(posedge CLK) if (bus.CE1) bus.Q1 <= mem[bus.A1];

    always @(posedge CLK) begin
        #1;
        case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ~bus.out_ready;
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: expected stream and address order derived from each accepted command.
    beat_t       exp_q[$];
    logic [13:0] addr_q[$];
    logic [7:0]  pop_log[$];
    logic [13:0] ce_log[$];
    int          issued, popped;
    bit          m_active, m_zero, prev_stall;
    logic [7:0]  prev_data;
    logic        prev_last;
    int          acc_len;
    int unsigned acc_addr, acc_stride;

    always @(negedge CLK) begin
        if (RST) begin
            check("ce1_in_reset", bus.CE1, 0);
            exp_q.delete(); addr_q.delete();
            issued = 0; popped = 0;
            m_active = 0; m_zero = 0; prev_stall = 0;
        end else begin
            check("cmd_ready", bus.cmd_ready, !m_active);
            check("busy", bus.busy, m_active && !(!m_zero && bus.out_valid && bus.out_ready
                                                 && exp_q.size() > 0 && exp_q[0].last));
            if (prev_stall) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_data", bus.out_data, prev_data);
                check("hold_last", bus.out_last, prev_last);
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) check("spurious_valid", 1, 0);
                else begin
                    check("out_data", bus.out_data, exp_q[0].d);
                    check("out_last", bus.out_last, exp_q[0].last);
                end
            end
            if (bus.CE1) begin
                if (addr_q.size() == 0) check("spurious_ce1", 1, 0);
                else begin
                    check("a1", bus.A1, addr_q[0]);
                    void'(addr_q.pop_front());
                end
                ce_log.push_back(bus.A1);
                issued++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
            if (bus.cmd_valid && !m_active) begin
                acc_addr = bus.cmd_addr;
                acc_len  = int'(bus.cmd_len);
`ifdef SRAM_B_RD_STRIDE_EN
                acc_stride = bus.cmd_stride;
`else
                acc_stride = 1;
`endif
                for (int i = 0; i < acc_len; i++) begin
                    beat_t b;
                    b.d    = mem[14'(acc_addr + i * acc_stride)];
                    b.last = (i == acc_len - 1);
                    exp_q.push_back(b);
                    addr_q.push_back(14'(acc_addr + i * acc_stride));
                end
                m_active = 1;
                m_zero   = (acc_len == 0);
            end else if (m_active && m_zero) begin
                m_active = 0;
            end
            if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
                pop_log.push_back(bus.out_data);
                if (exp_q[0].last) m_active = 0;
                void'(exp_q.pop_front());
                popped++;
            end
            check("occupancy_le2", (issued - popped) <= 2, 1);
        end
    end

    task automatic send(input logic [13:0] a, input int l, input logic [13:0] s);
        bit got = 0;
        bus.cmd_addr  = a;
        bus.cmd_len   = 15'(l);
`ifdef SRAM_B_RD_STRIDE_EN
        bus.cmd_stride = s;
`else
        if (s != 14'd1) $display("note: stride ignored in this build");
`endif
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge CLK);
            if (bus.cmd_ready) begin got = 1; break; end
        end
        @(posedge CLK); #1;
        bus.cmd_valid = 1'b0;
        if (!got) check("cmd_accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit got = 0;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge CLK);
            if (bus.cmd_ready && exp_q.size() == 0) begin got = 1; break; end
        end
        if (!got) check("idle_timeout", 0, 1);
        @(posedge CLK); #1;
    endtask

    task automatic clear_logs();
        pop_log.delete();
        ce_log.delete();
    endtask

    initial begin
        RST = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
`ifdef SRAM_B_RD_STRIDE_EN
        bus.cmd_stride = '0;
`endif
        bus.out_ready = 1'b1;
        bus.Q1        = '0;

        // 1. reset
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_ce1", bus.CE1, 0);
        check("rst_a1", bus.A1, 0);
        check("rst_out_data", bus.out_data, 0);
        @(posedge CLK); #1;

        // 2. latency and back-to-back throughput
        rdy_mode = 0;
        clear_logs();
        send(14'h0010, 4, 14'd1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            check($sformatf("t2_ce1_k%0d", k), bus.CE1, (k <= 4));
            check($sformatf("t2_vld_k%0d", k), bus.out_valid, (k >= 3 && k <= 6));
            if (k >= 3 && k <= 6) begin
                check($sformatf("t2_data_k%0d", k), bus.out_data, 32'h10 + k - 3);
                check($sformatf("t2_last_k%0d", k), bus.out_last, (k == 6));
            end
        end
        wait_idle();

        // 3. toggling consumer
        rdy_mode = 1;
        clear_logs();
        send(14'h0000, 8, 14'd1);
        wait_idle();
        check("t3_count", pop_log.size(), 8);
        for (int i = 0; i < 8 && i < pop_log.size(); i++)
            check($sformatf("t3_word%0d", i), pop_log[i], i);

        // 4. address wrap
        rdy_mode = 0;
        clear_logs();
        send(14'h3FFE, 4, 14'd1);
        wait_idle();
        begin
            logic [13:0] ea [4];
            logic [7:0]  ed [4];
            ea[0] = 14'h3FFE; ea[1] = 14'h3FFF; ea[2] = 14'h0000; ea[3] = 14'h0001;
            ed[0] = 8'hFE;    ed[1] = 8'hFF;    ed[2] = 8'h00;    ed[3] = 8'h01;
            check("t4_ce_count", ce_log.size(), 4);
            check("t4_pop_count", pop_log.size(), 4);
            for (int i = 0; i < 4 && i < ce_log.size(); i++) check($sformatf("t4_a1_%0d", i), ce_log[i], ea[i]);
            for (int i = 0; i < 4 && i < pop_log.size(); i++) check($sformatf("t4_d_%0d", i), pop_log[i], ed[i]);
        end

        // 5. zero-length burst
        clear_logs();
        send(14'h0100, 0, 14'd1);
        @(negedge CLK);
        check("t5_busy_k1", bus.busy, 1);
        check("t5_rdy_k1", bus.cmd_ready, 0);
        @(negedge CLK);
        check("t5_busy_k2", bus.busy, 0);
        check("t5_rdy_k2", bus.cmd_ready, 1);
        repeat (3) @(negedge CLK);
        check("t5_no_ce1", ce_log.size(), 0);
        check("t5_no_out", pop_log.size(), 0);
        @(posedge CLK); #1;

        // 6. reset mid-burst, then a fresh burst
        clear_logs();
        send(14'h0040, 6, 14'd1);
        begin
            bit got = 0;
            for (int i = 0; i < BOUND; i++) begin
                @(negedge CLK);
                if (pop_log.size() >= 2) begin got = 1; break; end
            end
            if (!got) check("t6_wait_timeout", 0, 1);
        end
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        check("t6_vld", bus.out_valid, 0);
        check("t6_last", bus.out_last, 0);
        check("t6_data", bus.out_data, 0);
        check("t6_ce1", bus.CE1, 0);
        check("t6_a1", bus.A1, 0);
        check("t6_busy", bus.busy, 0);
        check("t6_rdy", bus.cmd_ready, 1);
        @(posedge CLK); #1;
        clear_logs();
        send(14'h0020, 2, 14'd1);
        wait_idle();
        repeat (3) @(posedge CLK);
        #1;
        check("t6_pop_count", pop_log.size(), 2);
        if (pop_log.size() >= 2) begin
            check("t6_w0", pop_log[0], 8'h20);
            check("t6_w1", pop_log[1], 8'h21);
        end

`ifdef SRAM_B_RD_STRIDE_EN
        // 7. strided burst
        clear_logs();
        send(14'h0000, 3, 14'd3);
        wait_idle();
        check("t7_ce_count", ce_log.size(), 3);
        check("t7_pop_count", pop_log.size(), 3);
        for (int i = 0; i < 3 && i < ce_log.size(); i++) check($sformatf("t7_a1_%0d", i), ce_log[i], 3 * i);
        for (int i = 0; i < 3 && i < pop_log.size(); i++) check($sformatf("t7_d_%0d", i), pop_log[i], 3 * i);
`endif

        // randomized bursts under a random consumer, commands presented while busy
        rdy_mode = 2;
        for (int n = 0; n < 30; n++) begin
            logic [13:0] a;
            logic [13:0] s;
            int          l;
            a = ($urandom_range(0, 3) == 0) ? 14'(14'h3FF8 + $urandom_range(0, 7)) : 14'($urandom);
            l = $urandom_range(0, 12);
`ifdef SRAM_B_RD_STRIDE_EN
            s = 14'($urandom_range(0, 7));
`else
            s = 14'd1;
`endif
            send(a, l, s);
        end
        wait_idle();
        rdy_mode = 0;
        repeat (4) @(posedge CLK);
        #1;
        check("final_exp_empty", exp_q.size(), 0);
        check("final_addr_empty", addr_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
